// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel stream path.
//   PIXEL_W      : pixel / UART byte width
//   edge_state_t : Edge stage states (E_IDLE, E_WAIT)
//   tx_state_t   : TX stage states (T_IDLE, T_ARM, T_WAIT)
package pixel_pkg;
   localparam int PIXEL_W = 8;

   typedef enum logic {E_IDLE, E_WAIT} edge_state_t;
   typedef enum logic [1:0] {T_IDLE, T_ARM, T_WAIT} tx_state_t;
endpackage

// File: rtl/pixel_stream_ctrl_if.sv
// UART and Edge filter signals seen by the pixel stream controller.
//   master : controller side (drives transmit/data_tx/edge_en/edge_in)
//   slave  : UART + Edge filter side (drives recieved/data_rx/busy_tx/edge_out)
interface pixel_stream_ctrl_if;
   import pixel_pkg::*;

   logic               recieved;
   logic [PIXEL_W-1:0] data_rx;
   logic               busy_tx;
   logic               transmit;
   logic [PIXEL_W-1:0] data_tx;
   logic               edge_en;
   logic [PIXEL_W-1:0] edge_in;
   logic [PIXEL_W-1:0] edge_out;

   modport master (
      input  recieved, data_rx, busy_tx, edge_out,
      output transmit, data_tx, edge_en, edge_in
   );

   modport slave (
      output recieved, data_rx, busy_tx, edge_out,
      input  transmit, data_tx, edge_en, edge_in
   );
endinterface

// File: rtl/pixel_stream_ctrl_sync_fifo.sv
// Single-clock circular FIFO with pointers one bit wider than the index,
// so full and empty are told apart by the pointer difference.
//   clk, rst_n  : clock, async active-low reset
//   push, din   : write strobe and data
//   pop, dout   : read strobe and head data (dout shows head combinationally)
//   level       : number of stored entries
//   empty, full : status flags
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic [$clog2(DEPTH):0] level,
   output logic                   empty,
   output logic                   full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             push_ok, pop_ok;

   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign level = wr_ptr - rd_ptr;
   assign empty = (level == '0);
   assign full  = (level == (AW+1)'(DEPTH));
endmodule

// File: rtl/pixel_stream_ctrl.sv
// Sequences UART RX -> Edge filter -> result FIFO -> UART TX.
//   clk, rst_n : 50 MHz clock, async active-low reset
//   io         : UART/Edge handshake bundle (master side)
//   fifo_level : entries currently in the result FIFO
//   drop_cnt   : saturating count of bytes dropped (FIFO full or Edge busy)
//   active     : Edge or TX stage busy, or FIFO non-empty
module pixel_stream_ctrl
   import pixel_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int EDGE_LAT   = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   pixel_stream_ctrl_if.master         io,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [7:0]                  drop_cnt,
   output logic                        active
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   edge_state_t        e_state, e_next;
   tx_state_t          t_state, t_next;
   logic               rcv_q, rx_evt;
   logic [3:0]         lat_cnt;
   logic               arm_cnt;
   logic               accept, drop, push, pop;
   logic [LVL_W:0]     slots_used;
   logic [PIXEL_W-1:0] fifo_dout;
   logic               fifo_empty, fifo_full;

   // rcv_q resets high so a receive flag already set out of reset is ignored
   assign rx_evt = io.recieved & ~rcv_q;

   // The in-flight Edge byte already owns a FIFO slot
   assign slots_used = {1'b0, fifo_level} + (LVL_W+1)'(e_state == E_WAIT);

   always_comb begin
      e_next = e_state;
      accept = 1'b0;
      drop   = 1'b0;
      push   = 1'b0;
      case (e_state)
         E_IDLE: begin
            if (rx_evt) begin
               if (slots_used < (LVL_W+1)'(FIFO_DEPTH)) begin
                  accept = 1'b1;
                  e_next = E_WAIT;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         E_WAIT: begin
            drop = rx_evt;
            // Countdown runs after the edge_en cycle, so the capture lands
            // EDGE_LAT cycles after the enable pulse.
            if (lat_cnt == '0 && !io.edge_en) begin
               push   = 1'b1;
               e_next = E_IDLE;
            end
         end
         default: e_next = E_IDLE;
      endcase
   end

   always_comb begin
      t_next = t_state;
      pop    = 1'b0;
      case (t_state)
         T_IDLE: begin
            if (!fifo_empty && !io.busy_tx) begin
               pop    = 1'b1;
               t_next = T_ARM;
            end
         end
         // Give the transmitter two cycles to raise busy; one that completes
         // instantly never does.
         T_ARM:   if (io.busy_tx || arm_cnt) t_next = T_WAIT;
         T_WAIT:  if (!io.busy_tx) t_next = T_IDLE;
         default: t_next = T_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcv_q       <= 1'b1;
         e_state     <= E_IDLE;
         t_state     <= T_IDLE;
         lat_cnt     <= '0;
         arm_cnt     <= 1'b0;
         io.edge_en  <= 1'b0;
         io.edge_in  <= '0;
         io.transmit <= 1'b0;
         io.data_tx  <= '0;
         drop_cnt    <= '0;
      end else begin
         rcv_q   <= io.recieved;
         e_state <= e_next;
         t_state <= t_next;

         io.edge_en <= accept;
         if (accept) begin
            io.edge_in <= io.data_rx;
            lat_cnt    <= 4'(EDGE_LAT - 1);
         end else if (e_state == E_WAIT && !io.edge_en && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
         end

         if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;

         io.transmit <= pop;
         if (pop) io.data_tx <= fifo_dout;
         arm_cnt <= (t_state == T_ARM);
      end
   end

   sync_fifo #(
      .WIDTH (PIXEL_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (io.edge_out),
      .pop   (pop),
      .dout  (fifo_dout),
      .level (fifo_level),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign active = (e_state != E_IDLE) || (t_state != T_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_pixel_stream_ctrl.sv
// Directed bench for pixel_stream_ctrl: Edge filter modelled as a registered
// inverter (EDGE_LAT=1), UART TX modelled as busy for one cycle per byte
// plus a force-busy override for back-pressure.
module tb_pixel_stream_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] fifo_level;
   logic [7:0] drop_cnt;
   logic       active;
   logic       busy_force = 1'b0;
   logic       busy_model = 1'b0;
   int         busy_cnt = 0;
   logic [7:0] tx_log [512];
   int         tx_n = 0;
   int         total = 0;
   int         bad = 0;

   pixel_stream_ctrl_if io ();

   pixel_stream_ctrl #(.FIFO_DEPTH(4), .EDGE_LAT(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .io         (io),
      .fifo_level (fifo_level),
      .drop_cnt   (drop_cnt),
      .active     (active)
   );

   always #5 clk = ~clk;

   assign io.busy_tx = busy_force | busy_model;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)          io.edge_out <= 8'h00;
      else if (io.edge_en) io.edge_out <= ~io.edge_in;
   end

   always @(negedge clk) begin
      if (io.transmit) begin
         if (tx_n < 512) tx_log[tx_n] = io.data_tx;
         tx_n = tx_n + 1;
         busy_cnt = 1;
      end else if (busy_cnt > 0) begin
         busy_cnt = busy_cnt - 1;
      end
      busy_model = (busy_cnt != 0);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      io.recieved = 1'b0;
      io.data_rx = 8'h00;
      busy_force = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   // One byte every 4 cycles: the Edge stage is back in E_IDLE in time
   task automatic send_byte(input logic [7:0] b);
      io.recieved = 1'b1;
      io.data_rx = b;
      tick(1);
      io.recieved = 1'b0;
      tick(3);
   endtask

   initial begin
      int base;
      logic [7:0] b;

      // reset state
      io.recieved = 1'b0;
      io.data_rx = 8'h00;
      #2;
      chk("rst_transmit", {31'd0, io.transmit}, 32'd0);
      chk("rst_edge_en", {31'd0, io.edge_en}, 32'd0);
      chk("rst_edge_in", {24'd0, io.edge_in}, 32'd0);
      chk("rst_data_tx", {24'd0, io.data_tx}, 32'd0);
      chk("rst_level", {29'd0, fifo_level}, 32'd0);
      chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
      chk("rst_active", {31'd0, active}, 32'd0);

      // single byte: transmit exactly 4 cycles after recieved rises
      do_reset();
      base = tx_n;
      io.recieved = 1'b1;
      io.data_rx = 8'h3C;
      tick(1);
      chk("single_edge_en", {31'd0, io.edge_en}, 32'd1);
      chk("single_edge_in", {24'd0, io.edge_in}, 32'h3C);
      io.recieved = 1'b0;
      tick(1);
      chk("single_tx_early2", {31'd0, io.transmit}, 32'd0);
      tick(1);
      chk("single_tx_early3", {31'd0, io.transmit}, 32'd0);
      chk("single_level", {29'd0, fifo_level}, 32'd1);
      tick(1);
      chk("single_transmit", {31'd0, io.transmit}, 32'd1);
      chk("single_data_tx", {24'd0, io.data_tx}, 32'hC3);
      chk("single_drop", {24'd0, drop_cnt}, 32'd0);
      tick(10);
      chk("single_count", tx_n - base, 32'd1);
      chk("single_idle", {31'd0, active}, 32'd0);

      // back-pressure: 6 bytes into a 4-deep FIFO
      do_reset();
      busy_force = 1'b1;
      base = tx_n;
      for (int i = 1; i <= 6; i++) send_byte(8'(i));
      chk("bp_level", {29'd0, fifo_level}, 32'd4);
      chk("bp_drop", {24'd0, drop_cnt}, 32'd2);
      chk("bp_no_tx", tx_n - base, 32'd0);
      busy_force = 1'b0;
      tick(30);
      chk("bp_count", tx_n - base, 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("bp_tx%0d", i), {24'd0, tx_log[base+i]}, 32'(8'hFE - i));
      chk("bp_level_end", {29'd0, fifo_level}, 32'd0);

      // push and pop in the same cycle at level 2
      do_reset();
      busy_force = 1'b1;
      base = tx_n;
      send_byte(8'h11);
      send_byte(8'h22);
      io.recieved = 1'b1;
      io.data_rx = 8'h33;
      tick(1);
      io.recieved = 1'b0;
      tick(1);
      chk("pp_level_before", {29'd0, fifo_level}, 32'd2);
      busy_force = 1'b0;
      tick(1);
      chk("pp_level_same", {29'd0, fifo_level}, 32'd2);
      chk("pp_transmit", {31'd0, io.transmit}, 32'd1);
      tick(20);
      chk("pp_count", tx_n - base, 32'd3);
      chk("pp_tx0", {24'd0, tx_log[base]}, 32'hEE);
      chk("pp_tx1", {24'd0, tx_log[base+1]}, 32'hDD);
      chk("pp_tx2", {24'd0, tx_log[base+2]}, 32'hCC);

      // pointer wrap: 20 bytes through an idle transmitter
      do_reset();
      base = tx_n;
      for (int i = 0; i < 20; i++) send_byte(8'(8'h10 + i));
      tick(20);
      chk("wrap_count", tx_n - base, 32'd20);
      for (int i = 0; i < 20; i++) begin
         b = 8'(8'h10 + i);
         chk($sformatf("wrap_tx%0d", i), {24'd0, tx_log[base+i]}, {24'd0, ~b});
      end
      chk("wrap_drop", {24'd0, drop_cnt}, 32'd0);

      // reset mid-operation: 3 queued, one in E_WAIT
      do_reset();
      busy_force = 1'b1;
      for (int i = 0; i < 3; i++) send_byte(8'(8'h40 + i));
      io.recieved = 1'b1;
      io.data_rx = 8'h44;
      tick(1);
      chk("mid_level", {29'd0, fifo_level}, 32'd3);
      chk("mid_edge_en", {31'd0, io.edge_en}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_edge_en", {31'd0, io.edge_en}, 32'd0);
      chk("mid_rst_edge_in", {24'd0, io.edge_in}, 32'd0);
      chk("mid_rst_level", {29'd0, fifo_level}, 32'd0);
      chk("mid_rst_active", {31'd0, active}, 32'd0);
      chk("mid_rst_transmit", {31'd0, io.transmit}, 32'd0);
      #2;
      rst_n = 1'b1;
      busy_force = 1'b0;
      tick(4);
      chk("mid_post_edge_en", {31'd0, io.edge_en}, 32'd0);
      chk("mid_post_active", {31'd0, active}, 32'd0);
      chk("mid_post_level", {29'd0, fifo_level}, 32'd0);
      io.recieved = 1'b0;
      tick(1);

      // drop counter saturation
      do_reset();
      busy_force = 1'b1;
      for (int i = 0; i < 300; i++) send_byte(8'(i));
      chk("sat_drop", {24'd0, drop_cnt}, 32'd255);
      chk("sat_level", {29'd0, fifo_level}, 32'd4);
      send_byte(8'hAA);
      send_byte(8'hBB);
      chk("sat_hold", {24'd0, drop_cnt}, 32'd255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
